// File: rtl/alu_ex_if.sv
// Handshake and payload bundle between an EX-stage ALU and its producer/consumer.
interface alu_ex_if #(
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned FUNC_W = 6;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] A;
    logic [DATA_W-1:0] B;
    logic              Signed;
    logic [FUNC_W-1:0] ALUFunc;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] A_q;
    logic [DATA_W-1:0] B_q;
    logic              Signed_q;
    logic [FUNC_W-1:0] ALUFunc_q;
    logic [DATA_W-1:0] S;
    logic              ovf;
    logic              bad_func;
    logic              pulse;

    // Producer/consumer side of the stage.
    modport master (
        output in_valid, A, B, Signed, ALUFunc, out_ready,
        input  in_ready, out_valid, A_q, B_q, Signed_q, ALUFunc_q, S, ovf, bad_func, pulse
    );

    // The ALU stage itself.
    modport slave (
        input  in_valid, A, B, Signed, ALUFunc, out_ready,
        output in_ready, out_valid, A_q, B_q, Signed_q, ALUFunc_q, S, ovf, bad_func, pulse
    );
endinterface

// File: rtl/alu_ex_stage.sv
// Registered EX-stage ALU: latch one op, compute S, hold it until the consumer takes it.
module alu_ex_stage #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned SHAMT_W  = 5,
    parameter bit          PULSE_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    alu_ex_if.slave    bus
);
    localparam int unsigned FUNC_W = 6;
    localparam int unsigned MSB    = DATA_W - 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [FUNC_W-1:0] FN_ADD = 6'b000000;
    localparam logic [FUNC_W-1:0] FN_SUB = 6'b000001;
    localparam logic [FUNC_W-1:0] FN_AND = 6'b011000;
    localparam logic [FUNC_W-1:0] FN_OR  = 6'b011110;
    localparam logic [FUNC_W-1:0] FN_XOR = 6'b010110;
    localparam logic [FUNC_W-1:0] FN_NOR = 6'b010001;
    localparam logic [FUNC_W-1:0] FN_A   = 6'b011010;
    localparam logic [FUNC_W-1:0] FN_SLL = 6'b100000;
    localparam logic [FUNC_W-1:0] FN_SRL = 6'b100001;
    localparam logic [FUNC_W-1:0] FN_SRA = 6'b100011;
    localparam logic [FUNC_W-1:0] FN_EQ  = 6'b110011;
    localparam logic [FUNC_W-1:0] FN_NEQ = 6'b110001;
    localparam logic [FUNC_W-1:0] FN_LT  = 6'b110101;
    localparam logic [FUNC_W-1:0] FN_LEZ = 6'b111101;
    localparam logic [FUNC_W-1:0] FN_GEZ = 6'b111001;
    localparam logic [FUNC_W-1:0] FN_GTZ = 6'b111111;

    logic [1:0]        state;
    logic [1:0]        state_d;
    logic              in_ready_q;
    logic              in_ready_d;
    logic              out_valid_q;
    logic              out_valid_d;
    logic              pulse_q;
    logic              pulse_d;
    logic              accept_c;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              signed_q;
    logic [FUNC_W-1:0] func_q;
    logic [DATA_W-1:0] s_q;
    logic              ovf_q;
    logic              bad_q;

    logic [DATA_W-1:0] res_c;
    logic              ovf_c;
    logic              bad_c;
    logic [DATA_W-1:0] sum_c;
    logic [DATA_W-1:0] diff_c;
    logic [SHAMT_W-1:0] shamt_c;
    logic              lt_c;

    // Next-state and next registered handshake/strobe values.
    always_comb begin
        state_d     = state;
        accept_c    = 1'b0;
        pulse_d     = 1'b0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    accept_c = 1'b1;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_DONE;
                pulse_d = PULSE_EN;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State register plus registered handshake outputs and print strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            pulse_q     <= 1'b0;
        end else begin
            state       <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            pulse_q     <= pulse_d;
        end
    end

    // ALU function evaluated on the latched operands.
    always_comb begin
        res_c   = '0;
        ovf_c   = 1'b0;
        bad_c   = 1'b0;
        sum_c   = a_q + b_q;
        diff_c  = a_q - b_q;
        shamt_c = a_q[SHAMT_W-1:0];
        lt_c    = signed_q ? ($signed(a_q) < $signed(b_q)) : (a_q < b_q);
        case (func_q)
            FN_ADD: begin
                res_c = sum_c;
                ovf_c = signed_q && (a_q[MSB] == b_q[MSB]) && (sum_c[MSB] != a_q[MSB]);
            end
            FN_SUB: begin
                res_c = diff_c;
                ovf_c = signed_q && (a_q[MSB] != b_q[MSB]) && (diff_c[MSB] != a_q[MSB]);
            end
            FN_AND: res_c = a_q & b_q;
            FN_OR:  res_c = a_q | b_q;
            FN_XOR: res_c = a_q ^ b_q;
            FN_NOR: res_c = ~(a_q | b_q);
            FN_A:   res_c = a_q;
            FN_SLL: res_c = b_q << shamt_c;
            FN_SRL: res_c = b_q >> shamt_c;
            FN_SRA: res_c = DATA_W'($signed(b_q) >>> shamt_c);
            FN_EQ:  res_c = DATA_W'(a_q == b_q);
            FN_NEQ: res_c = DATA_W'(a_q != b_q);
            FN_LT:  res_c = DATA_W'(lt_c);
            FN_LEZ: res_c = DATA_W'(a_q[MSB] || (a_q == '0));
            FN_GEZ: res_c = DATA_W'(!a_q[MSB]);
            FN_GTZ: res_c = DATA_W'(!a_q[MSB] && (a_q != '0));
            default: bad_c = 1'b1;
        endcase
    end

    // Operand latch on accept, result capture in EXEC; everything holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            func_q   <= '0;
            s_q      <= '0;
            ovf_q    <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            if (accept_c) begin
                a_q      <= bus.A;
                b_q      <= bus.B;
                signed_q <= bus.Signed;
                func_q   <= bus.ALUFunc;
            end
            if (state == ST_EXEC) begin
                s_q   <= res_c;
                ovf_q <= ovf_c;
                bad_q <= bad_c;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.pulse     = pulse_q;
    assign bus.A_q       = a_q;
    assign bus.B_q       = b_q;
    assign bus.Signed_q  = signed_q;
    assign bus.ALUFunc_q = func_q;
    assign bus.S         = s_q;
    assign bus.ovf       = ovf_q;
    assign bus.bad_func  = bad_q;

endmodule

// File: tb/tb_alu_ex_stage.sv
// Scoreboard bench for alu_ex_stage: driver pushes expectations, negedge monitor pops and checks.
module tb_alu_ex_stage;
    localparam int unsigned DW = 32;

    localparam logic [5:0] F_ADD = 6'b000000;
    localparam logic [5:0] F_SUB = 6'b000001;
    localparam logic [5:0] F_AND = 6'b011000;
    localparam logic [5:0] F_OR  = 6'b011110;
    localparam logic [5:0] F_XOR = 6'b010110;
    localparam logic [5:0] F_NOR = 6'b010001;
    localparam logic [5:0] F_A   = 6'b011010;
    localparam logic [5:0] F_SLL = 6'b100000;
    localparam logic [5:0] F_SRL = 6'b100001;
    localparam logic [5:0] F_SRA = 6'b100011;
    localparam logic [5:0] F_EQ  = 6'b110011;
    localparam logic [5:0] F_NEQ = 6'b110001;
    localparam logic [5:0] F_LT  = 6'b110101;
    localparam logic [5:0] F_LEZ = 6'b111101;
    localparam logic [5:0] F_GEZ = 6'b111001;
    localparam logic [5:0] F_GTZ = 6'b111111;

    localparam longint MAXS = 64'sd2147483647;
    localparam longint MINS = -64'sd2147483648;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        logic [5:0]  f;
        logic [31:0] s;
        logic        ovf;
        logic        bad;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_ex_if #(.DATA_W(DW)) bus ();

    alu_ex_stage #(.DATA_W(DW), .SHAMT_W(5), .PULSE_EN(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          rdy_mode = 0;   // 0 random, 1 held low, 2 held high
    bit          mon_en = 1'b0;
    logic        prev_ov = 1'b0;
    logic [31:0] held_s = '0;
    logic [5:0]  codes[16] = '{F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_NOR, F_A, F_SLL,
                               F_SRL, F_SRA, F_EQ, F_NEQ, F_LT, F_LEZ, F_GEZ, F_GTZ};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model written from the operation definitions using wide integer arithmetic.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                  input logic [5:0] f, output logic [31:0] s,
                                  output logic ovf, output logic bad);
        longint sa, sbv, ua, ub, r, p, q;
        int     sh;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        sh  = int'(a[4:0]);
        p   = 1;
        for (int i = 0; i < sh; i++) p = p * 2;
        s = '0; ovf = 1'b0; bad = 1'b0;
        case (f)
            F_ADD: begin r = sa + sbv; s = r[31:0]; ovf = sg && (r > MAXS || r < MINS); end
            F_SUB: begin r = sa - sbv; s = r[31:0]; ovf = sg && (r > MAXS || r < MINS); end
            F_AND: s = a & b;
            F_OR:  s = a | b;
            F_XOR: s = a ^ b;
            F_NOR: s = ~(a | b);
            F_A:   s = a;
            F_SLL: begin r = ub * p; s = r[31:0]; end
            F_SRL: begin r = ub / p; s = r[31:0]; end
            F_SRA: begin
                q = sbv / p;
                if (sbv < 0 && (sbv % p) != 0) q = q - 1;
                s = q[31:0];
            end
            F_EQ:  s = (a == b) ? 32'd1 : 32'd0;
            F_NEQ: s = (a != b) ? 32'd1 : 32'd0;
            F_LT:  s = (sg ? (sa < sbv) : (ua < ub)) ? 32'd1 : 32'd0;
            F_LEZ: s = (sa <= 0) ? 32'd1 : 32'd0;
            F_GEZ: s = (sa >= 0) ? 32'd1 : 32'd0;
            F_GTZ: s = (sa > 0) ? 32'd1 : 32'd0;
            default: bad = 1'b1;
        endcase
    endfunction

    // Offer one op (called at posedge+1); returns at posedge+1 right after the accepting edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sg,
                         input logic [5:0] f, input bit use_exp, input logic [31:0] s_exp,
                         input logic ovf_exp, input logic bad_exp);
        exp_t e;
        int   n;
        bus.A = a; bus.B = b; bus.Signed = sg; bus.ALUFunc = f; bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        e.a = a; e.b = b; e.sg = sg; e.f = f;
        if (use_exp) begin
            e.s = s_exp; e.ovf = ovf_exp; e.bad = bad_exp;
        end else begin
            model(a, b, sg, f, e.s, e.ovf, e.bad);
        end
        sb.push_back(e);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: pulse shape, output stability in DONE, consumer handshake and scoreboard compare.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("pulse", 64'(bus.pulse), 64'(bus.out_valid && !prev_ov));
            if (bus.out_valid && prev_ov) chk("S_hold", 64'(bus.S), 64'(held_s));
            case (rdy_mode)
                1:       bus.out_ready = 1'b0;
                2:       bus.out_ready = 1'b1;
                default: bus.out_ready = ($urandom_range(0, 9) < 7);
            endcase
            if (bus.out_valid && bus.out_ready && !reset) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 64'(bus.out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("S",         64'(bus.S),         64'(e.s));
                    chk("ovf",       64'(bus.ovf),       64'(e.ovf));
                    chk("bad_func",  64'(bus.bad_func),  64'(e.bad));
                    chk("A_q",       64'(bus.A_q),       64'(e.a));
                    chk("B_q",       64'(bus.B_q),       64'(e.b));
                    chk("Signed_q",  64'(bus.Signed_q),  64'(e.sg));
                    chk("ALUFunc_q", 64'(bus.ALUFunc_q), 64'(e.f));
                end
            end
            prev_ov = bus.out_valid;
            held_s  = bus.S;
        end
    end

    task automatic check_cleared(input string tag);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_pulse"},     64'(bus.pulse),     64'd0);
        chk({tag, "_S"},         64'(bus.S),         64'd0);
        chk({tag, "_A_q"},       64'(bus.A_q),       64'd0);
        chk({tag, "_B_q"},       64'(bus.B_q),       64'd0);
        chk({tag, "_ALUFunc_q"}, 64'(bus.ALUFunc_q), 64'd0);
        chk({tag, "_Signed_q"},  64'(bus.Signed_q),  64'd0);
        chk({tag, "_ovf"},       64'(bus.ovf),       64'd0);
        chk({tag, "_bad_func"},  64'(bus.bad_func),  64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [5:0]  rf;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Signed = 1'b0; bus.ALUFunc = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_cleared("rst");
        reset = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // 1: signed overflow, latency and pulse
        rdy_mode = 1;
        issue(32'h7FFFFFFF, 32'h1, 1'b1, F_ADD, 1'b1, 32'h80000000, 1'b1, 1'b0);
        chk("lat_exec_out_valid", 64'(bus.out_valid), 64'd0);
        chk("lat_exec_in_ready",  64'(bus.in_ready),  64'd0);
        @(posedge clk); #1;
        chk("lat_done_out_valid", 64'(bus.out_valid), 64'd1);
        chk("lat_done_pulse",     64'(bus.pulse),     64'd1);
        chk("t1_S",               64'(bus.S),         64'h80000000);
        chk("t1_ovf",             64'(bus.ovf),       64'd1);
        rdy_mode = 2;
        drain();

        // 2: unsigned subtract wrap, signed vs unsigned LT
        rdy_mode = 0;
        issue(32'h0, 32'h1, 1'b0, F_SUB, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        issue(32'hFFFFFFFF, 32'h1, 1'b1, F_LT, 1'b1, 32'h1, 1'b0, 1'b0);
        issue(32'hFFFFFFFF, 32'h1, 1'b0, F_LT, 1'b1, 32'h0, 1'b0, 1'b0);

        // 3: shifts
        issue(32'd4, 32'h80000000, 1'b0, F_SRA, 1'b1, 32'hF8000000, 1'b0, 1'b0);
        issue(32'd4, 32'h80000000, 1'b0, F_SRL, 1'b1, 32'h08000000, 1'b0, 1'b0);
        issue(32'd31, 32'h1, 1'b0, F_SLL, 1'b1, 32'h80000000, 1'b0, 1'b0);

        // 6: unlisted code and zero compares
        issue(32'h12345678, 32'h9, 1'b1, 6'b000010, 1'b1, 32'h0, 1'b0, 1'b1);
        issue(32'h0, 32'h5, 1'b0, F_LEZ, 1'b1, 32'h1, 1'b0, 1'b0);
        issue(32'h0, 32'h5, 1'b0, F_GTZ, 1'b1, 32'h0, 1'b0, 1'b0);
        issue(32'h80000000, 32'h0, 1'b0, F_GEZ, 1'b1, 32'h0, 1'b0, 1'b0);
        drain();

        // 4: consumer stalls in DONE while upstream keeps offering
        rdy_mode = 1;
        issue(32'd5, 32'd6, 1'b0, F_ADD, 1'b1, 32'd11, 1'b0, 1'b0);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.A = $urandom; bus.B = $urandom; bus.ALUFunc = F_XOR;
            chk("stall_in_ready",  64'(bus.in_ready),  64'd0);
            chk("stall_out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall_A_q",       64'(bus.A_q),       64'd5);
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("stall_A_q_end", 64'(bus.A_q), 64'd5);
        rdy_mode = 2;
        drain();
        issue(32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, F_AND, 1'b1, 32'h00F000F0, 1'b0, 1'b0);
        drain();

        // 5: reset in EXEC drops the op; reset beats a simultaneous in_valid
        issue(32'd1, 32'd2, 1'b1, F_SUB, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        reset = 1'b1;
        sb.delete();
        bus.in_valid = 1'b1; bus.A = 32'hDEADBEEF; bus.B = 32'h1; bus.ALUFunc = F_OR;
        bus.Signed = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.in_valid = 1'b0;
        check_cleared("midrst");
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        chk("midrst_no_pulse",     64'(bus.pulse),     64'd0);
        chk("midrst_no_out_valid", 64'(bus.out_valid), 64'd0);
        issue(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, F_SUB, 1'b1, 32'h80000000, 1'b1, 1'b0);
        drain();

        // Random traffic against the reference model
        rdy_mode = 0;
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 5))
                0:       ra = 32'h7FFFFFFF;
                1:       ra = 32'h80000000;
                2:       ra = 32'h0;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'hFFFFFFFF;
                1:       rb = 32'h80000000;
                2:       rb = ra;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 9) == 0) rf = 6'($urandom);
            else rf = codes[$urandom_range(0, 15)];
            issue(ra, rb, 1'($urandom), rf, 1'b0, 32'h0, 1'b0, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        drain();
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
